// File: rtl/excitation_gen.sv
// LPC excitation source: per-frame pitch pulse train or LFSR noise, scaled by a latched gain.
// Optional EXCITATION_NOISE_MIX_EN adds 1/8-scale noise to voiced samples.
module excitation_gen #(
  parameter int          FRAME_LEN = 240,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        v,
  input  logic        voiced,
  input  logic [15:0] pitch,
  input  logic [15:0] gain,
  output logic [15:0] x,
  output logic        vout,
  output logic        frame_start
);

  localparam int             FCW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FCW-1:0] LAST = FCW'(FRAME_LEN - 1);

  logic [FCW-1:0] r_frame_cnt;
  logic [15:0]    r_pitch_cnt;
  logic [15:0]    r_lfsr;
  logic           r_voiced;
  logic [15:0]    r_pitch;
  logic [14:0]    r_gain;
  logic [15:0]    r_x;
  logic           r_vout;
  logic           r_frame_start;

  logic               w_new_frame;
  logic               w_voiced;
  logic [15:0]        w_pitch;
  logic [14:0]        w_gain;
  logic [15:0]        w_pcnt;
  logic [15:0]        w_pcnt_nxt;
  logic signed [31:0] w_prod;
  logic [15:0]        w_noise;
  logic [15:0]        w_pulse;
  logic [15:0]        w_x;
  logic [15:0]        w_lfsr_nxt;
`ifdef EXCITATION_NOISE_MIX_EN
  logic [17:0]        w_mix_sum;
`endif

  always_comb begin
    w_new_frame = (r_frame_cnt == '0);
    w_voiced    = w_new_frame ? voiced : r_voiced;
    w_pitch     = w_new_frame ? ((pitch < 16'd2) ? 16'd2 : pitch) : r_pitch;
    w_gain      = w_new_frame ? gain[14:0] : r_gain;
    // Entering voiced from noise (or from reset) restarts the pulse phase.
    w_pcnt      = (w_new_frame && voiced && !r_voiced) ? 16'd0 : r_pitch_cnt;
    w_lfsr_nxt  = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    w_prod = 32'($signed(r_lfsr)) * 32'($signed({1'b0, w_gain}));
    if (w_prod[31] != w_prod[30]) w_noise = w_prod[31] ? 16'h8000 : 16'h7FFF;
    else                          w_noise = w_prod[30:15];

    w_pulse    = 16'd0;
    w_pcnt_nxt = 16'd0;
    w_x        = w_noise;
    if (w_voiced) begin
      if (w_pcnt == 16'd0) begin
        w_pulse    = {1'b0, w_gain};
        w_pcnt_nxt = w_pitch - 16'd1;
      end else begin
        w_pcnt_nxt = w_pcnt - 16'd1;
      end
`ifdef EXCITATION_NOISE_MIX_EN
      w_mix_sum = {2'b00, w_pulse} + {{4{w_prod[31]}}, w_prod[31:18]};
      if (w_mix_sum[17:15] == 3'b000 || w_mix_sum[17:15] == 3'b111) w_x = w_mix_sum[15:0];
      else w_x = w_mix_sum[17] ? 16'h8000 : 16'h7FFF;
`else
      w_x = w_pulse;
`endif
    end
`ifdef EXCITATION_NOISE_MIX_EN
    else begin
      w_mix_sum = 18'd0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_cnt   <= '0;
      r_pitch_cnt   <= 16'd0;
      r_lfsr        <= LFSR_SEED;
      r_voiced      <= 1'b0;
      r_pitch       <= 16'd2;
      r_gain        <= 15'd0;
      r_x           <= 16'd0;
      r_vout        <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_vout        <= v;
      r_frame_start <= v && w_new_frame;
      if (v) begin
        r_frame_cnt <= (r_frame_cnt == LAST) ? '0 : r_frame_cnt + 1'b1;
        r_pitch_cnt <= w_pcnt_nxt;
        r_lfsr      <= w_lfsr_nxt;
        r_voiced    <= w_voiced;
        r_pitch     <= w_pitch;
        r_gain      <= w_gain;
        r_x         <= w_x;
      end
    end
  end

  assign x           = r_x;
  assign vout        = r_vout;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_excitation_gen.sv
// Directed self-checking bench for excitation_gen (default build, noise mix disabled).
module tb_excitation_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v = 1'b0;
  logic        voiced = 1'b0;
  logic [15:0] pitch = 16'd0;
  logic [15:0] gain = 16'd0;
  logic [15:0] x;
  logic        vout;
  logic        fs;

  int n_checks = 0;
  int n_fail   = 0;

  excitation_gen dut (
    .clk(clk), .rst(rst), .v(v), .voiced(voiced), .pitch(pitch), .gain(gain),
    .x(x), .vout(vout), .frame_start(fs)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic chk_sample(input string tag, input logic [15:0] exp_x, input logic exp_fs);
    chk({tag, "_x"}, x, exp_x);
    chk({tag, "_vout"}, {15'd0, vout}, 16'd1);
    chk({tag, "_fs"}, {15'd0, fs}, {15'd0, exp_fs});
  endtask

  task automatic step(input logic vin);
    v = vin;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v   = 1'b0;
    rst = 1'b0;
    #2;
    chk("rst_x", x, 16'd0);
    chk("rst_vout", {15'd0, vout}, 16'd0);
    chk("rst_fs", {15'd0, fs}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] noise(input logic [15:0] l, input logic [15:0] g);
    int ls, gi, p;
    ls = int'($signed(l));
    gi = int'({1'b0, g[14:0]});
    p  = (ls * gi) >>> 15;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  initial begin
    logic [15:0] l;
    logic [15:0] held;
    int k;
    logic pulse;

    // Reset state
    do_reset();
    step(1'b0);
    chk("idle_vout", {15'd0, vout}, 16'd0);

    // Voiced pitch=4, one full frame plus the first sample of the next
    voiced = 1'b1; pitch = 16'd4; gain = 16'd16384;
    for (int i = 0; i < 241; i++) begin
      step(1'b1);
      chk_sample("A", (i % 4 == 0) ? 16'd16384 : 16'd0, (i % 240 == 0));
    end
    step(1'b0);
    chk("A_hold_x", x, 16'd16384);
    chk("A_hold_vout", {15'd0, vout}, 16'd0);
    chk("A_hold_fs", {15'd0, fs}, 16'd0);

    // Pitch 0 clamps to 2
    do_reset();
    voiced = 1'b1; pitch = 16'd0; gain = 16'd100;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      chk_sample("B", (i % 2 == 0) ? 16'd100 : 16'd0, (i == 0));
    end

    // Unvoiced noise, mid-frame gain change ignored, next frame uses new gain
    do_reset();
    voiced = 1'b0; pitch = 16'd9; gain = 16'd32767;
    l = 16'hACE1;
    step(1'b1);
    chk_sample("C_first", 16'hACE1, 1'b1);
    l = lfsr_next(l);
    for (int i = 1; i < 244; i++) begin
      if (i == 100) gain = 16'd1000;
      step(1'b1);
      chk_sample("C", noise(l, (i < 240) ? 16'd32767 : 16'd1000), (i == 240));
      l = lfsr_next(l);
    end

    // Voiced pitch 7 then 5 with phase continuity across the frame boundary
    do_reset();
    voiced = 1'b1; pitch = 16'd7; gain = 16'd500;
    for (int i = 0; i < 256; i++) begin
      if (i == 50)  pitch = 16'd3;
      if (i == 200) pitch = 16'd5;
      pulse = (i < 240 && i % 7 == 0) || (i >= 245 && (i - 245) % 5 == 0);
      step(1'b1);
      chk_sample("D", pulse ? 16'd500 : 16'd0, (i == 0 || i == 240));
    end

    // Gapped strobe, voiced pitch 3
    do_reset();
    voiced = 1'b1; pitch = 16'd3; gain = 16'd777;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1);
      held = (k % 3 == 0) ? 16'd777 : 16'd0;
      chk_sample("E", held, (k == 0));
      k++;
      step(1'b0);
      chk("E_gap_x", x, held);
      chk("E_gap_vout", {15'd0, vout}, 16'd0);
    end

    // Gapped strobe, unvoiced: LFSR frozen while v=0
    do_reset();
    voiced = 1'b0; gain = 16'd32767;
    l = 16'hACE1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      held = noise(l, 16'd32767);
      chk_sample("E2", held, (i == 0));
      l = lfsr_next(l);
      step(1'b0);
      chk("E2_gap_x", x, held);
    end

    // Reset mid-frame: LFSR restarts at seed
    do_reset();
    voiced = 1'b0; gain = 16'd32767;
    for (int i = 0; i < 50; i++) step(1'b1);
    do_reset();
    step(1'b1);
    chk_sample("F_lfsr", 16'hACE1, 1'b1);

    // Reset mid voiced frame: first sample after reset is a fresh pulse
    do_reset();
    voiced = 1'b1; pitch = 16'd4; gain = 16'd16384;
    for (int i = 0; i < 102; i++) step(1'b1);
    do_reset();
    step(1'b1);
    chk_sample("F_pulse", 16'd16384, 1'b1);
    step(1'b1);
    chk_sample("F_next", 16'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
